// File: rtl/r22sdf_bitrev_reorder.sv
// Ping-pong reorder buffer: turns bit-reversed FFT output frames into natural order.
// Each frame is written at bit-reversed addresses of one bank while the other bank is read out linearly.
module r22sdf_bitrev_reorder #(
   parameter int data_resolution = 16,
   parameter int fft_pts_log2    = 6
) (
   input  logic                       sys_clk,
   input  logic                       sys_nrst,
   input  logic                       sys_en,
   input  logic                       din_valid,
   input  logic [data_resolution-1:0] din_r,
   input  logic [data_resolution-1:0] din_i,
   output logic                       dout_valid,
   output logic [data_resolution-1:0] dout_r,
   output logic [data_resolution-1:0] dout_i,
   output logic                       dout_last
);

   localparam int DW = data_resolution;
   localparam int AW = fft_pts_log2;
   localparam int N  = 1 << AW;

   typedef enum logic {IDLE, READ} state_t;

   // Bank select is the address MSB, so both banks share one array.
   logic [2*DW-1:0] mem_q [0:2*N-1];

   logic [AW-1:0] wr_cnt_q, rd_cnt_q;
   logic          wr_bank_q, rd_bank_q;
   logic [1:0]    full_q, full_d;
   state_t        state_q;
   logic          dout_valid_q, dout_last_q;
   logic [DW-1:0] dout_r_q, dout_i_q;

   logic          wr_en_d, wr_last_d, rd_last_d;
   logic [AW:0]   wr_addr_d, rd_addr_d;

   function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
      logic [AW-1:0] r;
      for (int j = 0; j < AW; j++) r[j] = a[AW-1-j];
      return r;
   endfunction

   assign wr_en_d   = sys_en & din_valid;
   assign wr_last_d = wr_en_d && (wr_cnt_q == '1);
   assign rd_last_d = (state_q == READ) && (rd_cnt_q == '1);
   assign wr_addr_d = {wr_bank_q, bitrev(wr_cnt_q)};
   assign rd_addr_d = {rd_bank_q, rd_cnt_q};

   // Writer never targets the bank being read, so set and clear hit different flags.
   always_comb begin
      full_d = full_q;
      if (rd_last_d) full_d[rd_bank_q] = 1'b0;
      if (wr_last_d) full_d[wr_bank_q] = 1'b1;
   end

   always_ff @(posedge sys_clk) begin
      if (sys_nrst && wr_en_d) mem_q[wr_addr_d] <= {din_r, din_i};
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_nrst) begin
         wr_cnt_q     <= '0;
         wr_bank_q    <= 1'b0;
         full_q       <= '0;
         state_q      <= IDLE;
         rd_cnt_q     <= '0;
         rd_bank_q    <= 1'b0;
         dout_valid_q <= 1'b0;
         dout_last_q  <= 1'b0;
         dout_r_q     <= '0;
         dout_i_q     <= '0;
      end else if (sys_en) begin
         full_q <= full_d;
         if (din_valid) begin
            wr_cnt_q <= wr_cnt_q + 1'b1;
            if (wr_last_d) wr_bank_q <= ~wr_bank_q;
         end
         dout_valid_q <= 1'b0;
         dout_last_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (|full_q) begin
                  state_q   <= READ;
                  rd_cnt_q  <= '0;
                  rd_bank_q <= ~full_q[0];
               end
            end
            READ: begin
               dout_valid_q           <= 1'b1;
               dout_last_q            <= rd_last_d;
               {dout_r_q, dout_i_q}   <= mem_q[rd_addr_d];
               rd_cnt_q               <= rd_cnt_q + 1'b1;
               // Chain straight into the other bank for gap-free streaming.
               if (rd_last_d) begin
                  if (full_q[~rd_bank_q]) rd_bank_q <= ~rd_bank_q;
                  else                    state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dout_valid = dout_valid_q;
   assign dout_last  = dout_last_q;
   assign dout_r     = dout_r_q;
   assign dout_i     = dout_i_q;

endmodule
